// File: rtl/bch_pkg.sv
// Shared constants, FSM encoding and GF(16) arithmetic (primitive polynomial x^4+x+1)
// for the BCH(15,7) t=2 decoder.
package bch_pkg;

    localparam int N = 15;
    localparam int K = 7;
    localparam int T = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYND  = 3'd1,
        KEY   = 3'd2,
        CHIEN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic [3:0] gf_t;

    localparam gf_t ALPHA   = 4'h2;
    localparam gf_t ALPHA3  = 4'h8;
    localparam gf_t ALPHA13 = 4'hD;
    localparam gf_t ALPHA14 = 4'h9;

    function automatic gf_t antilog_table(input logic [3:0] e);
        gf_t v;
        case (e)
            4'd0:    v = 4'h1;
            4'd1:    v = 4'h2;
            4'd2:    v = 4'h4;
            4'd3:    v = 4'h8;
            4'd4:    v = 4'h3;
            4'd5:    v = 4'h6;
            4'd6:    v = 4'hC;
            4'd7:    v = 4'hB;
            4'd8:    v = 4'h5;
            4'd9:    v = 4'hA;
            4'd10:   v = 4'h7;
            4'd11:   v = 4'hE;
            4'd12:   v = 4'hF;
            4'd13:   v = 4'hD;
            4'd14:   v = 4'h9;
            default: v = 4'h1;  // exponent 15 wraps to alpha^0
        endcase
        return v;
    endfunction

    // log(0) is undefined; callers test for zero before using the result.
    function automatic logic [3:0] log_table(input gf_t v);
        logic [3:0] e;
        case (v)
            4'h1:    e = 4'd0;
            4'h2:    e = 4'd1;
            4'h3:    e = 4'd4;
            4'h4:    e = 4'd2;
            4'h5:    e = 4'd8;
            4'h6:    e = 4'd5;
            4'h7:    e = 4'd10;
            4'h8:    e = 4'd3;
            4'h9:    e = 4'd14;
            4'hA:    e = 4'd9;
            4'hB:    e = 4'd7;
            4'hC:    e = 4'd6;
            4'hD:    e = 4'd13;
            4'hE:    e = 4'd11;
            4'hF:    e = 4'd12;
            default: e = 4'd0;
        endcase
        return e;
    endfunction

    function automatic gf_t gf_mult(input gf_t a, input gf_t b);
        logic [4:0] s;
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        s = {1'b0, log_table(a)} + {1'b0, log_table(b)};
        if (s >= 5'd15) s = s - 5'd15;
        return antilog_table(s[3:0]);
    endfunction

    function automatic gf_t gf_div(input gf_t a, input gf_t b);
        logic [4:0] s;
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        s = {1'b0, log_table(a)} + 5'd15 - {1'b0, log_table(b)};
        if (s >= 5'd15) s = s - 5'd15;
        return antilog_table(s[3:0]);
    endfunction

    function automatic gf_t gf_pow(input gf_t a, input int n);
        int e;
        if (n == 0) return 4'h1;
        if (a == 4'h0) return 4'h0;
        e = (int'(log_table(a)) * n) % 15;
        return antilog_table(4'(e));
    endfunction

endpackage

// File: rtl/bch15_decoder_ctrl_if.sv
// Word-in / result-out bundle of the BCH(15,7) decoder.
// Both directions use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; the source holds valid and payload stable until then.
interface bch15_decoder_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_data;
    logic [1:0]  out_err_cnt;
    logic        out_fail;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err_cnt, out_fail
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err_cnt, out_fail
    );
endinterface

// File: rtl/bch15_decoder_ctrl_gf.sv
// Combinational GF(16) multiplier and divider shared by the decoder datapath.
module gf_multiplier
    import bch_pkg::*;
(
    input  gf_t a_i,
    input  gf_t b_i,
    output gf_t p_o
);
    assign p_o = gf_mult(a_i, b_i);
endmodule

// A zero divisor yields zero; the decoder never relies on that value.
module gf_divider
    import bch_pkg::*;
(
    input  gf_t a_i,
    input  gf_t b_i,
    output gf_t q_o
);
    assign q_o = gf_div(a_i, b_i);
endmodule

// File: rtl/bch15_decoder_ctrl.sv
// Sequential BCH(15,7) t=2 decoder: serial syndromes, Peterson solve, serial Chien
// search, then holds the corrected word until the consumer takes it.
module bch15_decoder_ctrl
    import bch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    bch15_decoder_ctrl_if.slave  bus,
    output state_t               dbg_state_o
);

    state_t      state_q, state_d;
    logic [14:0] raw_q, raw_d;
    logic [14:0] cor_q, cor_d;
    gf_t         s1_q, s1_d;
    gf_t         s3_q, s3_d;
    gf_t         sigma1_q, sigma1_d;
    gf_t         sigma2_q, sigma2_d;
    gf_t         t1_q, t1_d;
    gf_t         t2_q, t2_d;
    logic [1:0]  deg_q, deg_d;
    logic        fail_q, fail_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  j_q, j_d;
    logic [1:0]  roots_q, roots_d;
    logic [14:0] out_data_q, out_data_d;
    logic [1:0]  out_err_cnt_q, out_err_cnt_d;
    logic        out_fail_q, out_fail_d;

    gf_t s1_sq, s1_cube, sigma2_quot, t1_next, t2_next;

    gf_multiplier u_s1_sq   (.a_i(s1_q),  .b_i(s1_q),    .p_o(s1_sq));
    gf_multiplier u_s1_cube (.a_i(s1_sq), .b_i(s1_q),    .p_o(s1_cube));
    gf_divider    u_sigma2  (.a_i(s3_q ^ s1_cube), .b_i(s1_q), .q_o(sigma2_quot));
    gf_multiplier u_t1_step (.a_i(t1_q),  .b_i(ALPHA14), .p_o(t1_next));
    gf_multiplier u_t2_step (.a_i(t2_q),  .b_i(ALPHA13), .p_o(t2_next));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            raw_q         <= '0;
            cor_q         <= '0;
            s1_q          <= '0;
            s3_q          <= '0;
            sigma1_q      <= '0;
            sigma2_q      <= '0;
            t1_q          <= '0;
            t2_q          <= '0;
            deg_q         <= '0;
            fail_q        <= 1'b0;
            cnt_q         <= '0;
            j_q           <= '0;
            roots_q       <= '0;
            out_data_q    <= '0;
            out_err_cnt_q <= '0;
            out_fail_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            raw_q         <= raw_d;
            cor_q         <= cor_d;
            s1_q          <= s1_d;
            s3_q          <= s3_d;
            sigma1_q      <= sigma1_d;
            sigma2_q      <= sigma2_d;
            t1_q          <= t1_d;
            t2_q          <= t2_d;
            deg_q         <= deg_d;
            fail_q        <= fail_d;
            cnt_q         <= cnt_d;
            j_q           <= j_d;
            roots_q       <= roots_d;
            out_data_q    <= out_data_d;
            out_err_cnt_q <= out_err_cnt_d;
            out_fail_q    <= out_fail_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        raw_d         = raw_q;
        cor_d         = cor_q;
        s1_d          = s1_q;
        s3_d          = s3_q;
        sigma1_d      = sigma1_q;
        sigma2_d      = sigma2_q;
        t1_d          = t1_q;
        t2_d          = t2_q;
        deg_d         = deg_q;
        fail_d        = fail_q;
        cnt_d         = cnt_q;
        j_d           = j_q;
        roots_d       = roots_q;
        out_data_d    = out_data_q;
        out_err_cnt_d = out_err_cnt_q;
        out_fail_d    = out_fail_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    raw_d   = bus.in_data;
                    cor_d   = bus.in_data;
                    s1_d    = '0;
                    s3_d    = '0;
                    cnt_d   = 4'(N - 1);
                    state_d = SYND;
                end
            end

            // Horner evaluation of r(alpha) and r(alpha^3), highest-order bit first.
            SYND: begin
                s1_d = gf_mult(s1_q, ALPHA)  ^ {3'b000, raw_q[cnt_q]};
                s3_d = gf_mult(s3_q, ALPHA3) ^ {3'b000, raw_q[cnt_q]};
                if (cnt_q == 4'd0) begin
                    state_d = KEY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            KEY: begin
                sigma1_d = s1_q;
                sigma2_d = '0;
                deg_d    = 2'd0;
                fail_d   = 1'b0;
                if (s1_q == 4'h0) begin
                    fail_d = (s3_q != 4'h0);
                end else if (s3_q == s1_cube) begin
                    deg_d = 2'd1;
                end else begin
                    sigma2_d = sigma2_quot;
                    deg_d    = 2'(T);
                end
                t1_d    = s1_q;
                t2_d    = sigma2_d;
                j_d     = '0;
                roots_d = '0;
                state_d = CHIEN;
            end

            // sigma(alpha^-j) == 0 marks an error at bit j.
            CHIEN: begin
                if ((4'h1 ^ t1_q ^ t2_q) == 4'h0) begin
                    cor_d   = cor_q ^ (15'(1) << j_q);
                    roots_d = (roots_q == 2'd3) ? 2'd3 : roots_q + 2'd1;
                end
                t1_d = t1_next;
                t2_d = t2_next;
                if (j_q == 4'(N - 1)) begin
                    state_d = DONE;
                    if (fail_q || (roots_d != deg_q)) begin
                        out_data_d    = raw_q;
                        out_err_cnt_d = 2'd0;
                        out_fail_d    = 1'b1;
                    end else begin
                        out_data_d    = cor_d;
                        out_err_cnt_d = deg_q;
                        out_fail_d    = 1'b0;
                    end
                end else begin
                    j_d = j_q + 4'd1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_data    = out_data_q;
    assign bus.out_err_cnt = out_err_cnt_q;
    assign bus.out_fail    = out_fail_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_bch15_decoder_ctrl.sv
// Directed bench for bch15_decoder_ctrl: hand-computed code vectors, backpressure,
// and reset abort during the Chien search.
module tb_bch15_decoder_ctrl;
    import bch_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    int errors = 0;
    int checks = 0;

    // {fail, err_cnt[1:0], data[14:0]}
    logic [17:0] exp_q[$];

    bch15_decoder_ctrl_if bus();

    bch15_decoder_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // driver: present one word and return #1 after the accepting edge
    task automatic send(input logic [14:0] w);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 15'($urandom_range(0, 32767));
        check("accept_state", 32'(dbg_state), 32'(SYND));
    endtask

    // scoreboard: wait for result, optionally stall, compare, then take it
    task automatic recv(input string tag, input int hold);
        int n;
        logic [17:0] exp;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd31);
        exp = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(bus.out_data), 32'(exp[14:0]));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp[14:0]));
        check({tag, "_err_cnt"}, 32'(bus.out_err_cnt), 32'(exp[16:15]));
        check({tag, "_fail"}, 32'(bus.out_fail), 32'(exp[17]));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [14:0] w, input logic [14:0] ed,
                           input logic [1:0] ee, input logic ef);
        send(w);
        exp_q.push_back({ef, ee, ed});
        recv(tag, 0);
    endtask

    initial begin
        int seen;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_err_cnt", 32'(bus.out_err_cnt), 32'd0);
        check("rst_fail", 32'(bus.out_fail), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        run_vec("zero",     15'h0000, 15'h0000, 2'd0, 1'b0);
        run_vec("codeword", 15'h01D1, 15'h01D1, 2'd0, 1'b0);
        run_vec("single3",  15'h01D9, 15'h01D1, 2'd1, 1'b0);
        run_vec("single14", 15'h41D1, 15'h01D1, 2'd1, 1'b0);
        run_vec("double",   15'h41D0, 15'h01D1, 2'd2, 1'b0);
        run_vec("double59", 15'h0220, 15'h0000, 2'd2, 1'b0);
        run_vec("uncorr",   15'h0013, 15'h0013, 2'd0, 1'b1);

        // backpressure: next word waits on in_valid until the output transfer
        send(15'h01D9);
        exp_q.push_back({1'b0, 2'd1, 15'h01D1});
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 15'h41D0;
        recv("bp", 10);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_accept_after_xfer", 32'(dbg_state), 32'(SYND));
        exp_q.push_back({1'b0, 2'd2, 15'h01D1});
        recv("bp_next", 0);

        // reset during the Chien search discards the word
        send(15'h01D9);
        repeat (20) @(posedge clk);
        #1;
        check("abort_in_chien", 32'(dbg_state), 32'(CHIEN));
        #2;
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 15'h0013;
        #1;
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_data", 32'(bus.out_data), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_accept", 32'(dbg_state), 32'(IDLE));
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        run_vec("recover", 15'h0220, 15'h0000, 2'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
